// File: rtl/tx_ddr_reader.sv
`default_nettype none
// ============================================================================
// Module   : tx_ddr_reader
// Purpose  : Reads a stored frame back from DDR with Avalon-MM burst reads,
//            buffers the 256-bit words and serializes them into an 8-bit
//            Avalon-ST stream for the TSE MAC transmit FIFO.
// Ports    : clk_original/rst_n        clock, async active-low reset
//            data_saved/size_received  frame-ready pulse and byte length
//            amm_*                     Avalon-MM burst read master
//            ff_tx_*                   Avalon-ST byte stream to the MAC
//            tx_busy/tx_done           frame status
//            start_dropped             pulse when a data_saved is ignored
// Revision : 1.0 - initial release
// ============================================================================
module tx_ddr_reader #(
    parameter int ADDR_W     = 25,
    parameter int BASE_ADDR  = 0,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BYTES  = 1518
) (
    input  logic              clk_original,
    input  logic              rst_n,
    input  logic              data_saved,
    input  logic [11:0]       size_received,
    output logic [ADDR_W-1:0] amm_addr,
    output logic              amm_read,
    output logic [6:0]        amm_burstcount,
    output logic [31:0]       amm_byteenable,
    input  logic              amm_waitrequest,
    input  logic [255:0]      amm_readdata,
    input  logic              amm_readdatavalid,
    output logic [7:0]        ff_tx_data,
    output logic              ff_tx_sop,
    output logic              ff_tx_eop,
    output logic              ff_tx_wren,
    output logic              ff_tx_err,
    output logic              ff_tx_crc_fwd,
    input  logic              ff_tx_rdy,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              start_dropped
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_amm_addr;
    logic              r_amm_read;
    logic [6:0]        r_amm_burstcount;
    logic [7:0]        r_words_left;
    logic [c_CW-1:0]   r_outstanding;
    logic [c_CW-1:0]   r_fifo_cnt;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [255:0]      r_mem [FIFO_DEPTH];
    logic [255:0]      r_word;
    logic              r_word_valid;
    logic [4:0]        r_byte_idx;
    logic [4:0]        r_last_idx;
    logic [11:0]       r_load_left;   // frame bytes not yet loaded into r_word
    logic              r_first;
    logic              r_tx_done;
    logic              r_start_dropped;

    logic              w_size_ok;
    logic [7:0]        w_size_words;
    logic [6:0]        w_start_burst;
    logic [6:0]        w_next_burst;
    logic [15:0]       w_credit;
    logic              w_mm_accept;
    logic              w_push;
    logic              w_word_end;
    logic              w_accept;
    logic              w_eop;
    logic              w_load;
    logic              w_frame_end;

    assign w_size_ok     = (size_received != 12'd0) && ({20'd0, size_received} <= 32'(MAX_BYTES));
    assign w_size_words  = 8'((13'(size_received) + 13'd31) >> 5);
    assign w_start_burst = (w_size_words > 8'(BURST_LEN)) ? 7'(BURST_LEN) : 7'(w_size_words);
    assign w_next_burst  = (r_words_left > 8'(BURST_LEN)) ? 7'(BURST_LEN) : 7'(r_words_left);

    // Slots not yet promised to either buffered or in-flight words.
    assign w_credit    = 16'(FIFO_DEPTH) - 16'(r_fifo_cnt) - 16'(r_outstanding);
    assign w_mm_accept = r_amm_read & ~amm_waitrequest;
    assign w_push      = amm_readdatavalid;

    assign w_word_end  = (r_byte_idx == r_last_idx);
    assign w_accept    = r_word_valid & ff_tx_rdy;
    assign w_eop       = r_word_valid & (r_load_left == 12'd0) & w_word_end;
    // Refill the word register when empty or on its last byte, so bytes flow back to back.
    assign w_load      = (r_state != c_IDLE) & (r_fifo_cnt != '0) & (r_load_left != 12'd0) &
                         (~r_word_valid | (w_accept & w_word_end));
    assign w_frame_end = w_accept & w_eop;

    always_ff @(posedge clk_original) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= amm_readdata;
        end
    end

    always_ff @(posedge clk_original or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_IDLE;
            r_amm_addr       <= '0;
            r_amm_read       <= 1'b0;
            r_amm_burstcount <= 7'd0;
            r_words_left     <= 8'd0;
            r_outstanding    <= '0;
            r_fifo_cnt       <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_word           <= '0;
            r_word_valid     <= 1'b0;
            r_byte_idx       <= 5'd0;
            r_last_idx       <= 5'd0;
            r_load_left      <= 12'd0;
            r_first          <= 1'b0;
            r_tx_done        <= 1'b0;
            r_start_dropped  <= 1'b0;
        end else begin
            r_tx_done       <= 1'b0;
            r_start_dropped <= 1'b0;

            // Buffer occupancy and in-flight accounting.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            case ({w_push, w_load})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            r_outstanding <= r_outstanding
                           + (w_mm_accept ? c_CW'(r_amm_burstcount) : c_CW'(0))
                           - (w_push ? c_CW'(1) : c_CW'(0));

            case (r_state)
                c_IDLE: begin
                    if (data_saved) begin
                        if (w_size_ok) begin
                            // Empty buffer guarantees credit for the first burst.
                            r_state          <= c_REQ;
                            r_words_left     <= w_size_words;
                            r_load_left      <= size_received;
                            r_amm_addr       <= ADDR_W'(BASE_ADDR);
                            r_amm_read       <= 1'b1;
                            r_amm_burstcount <= w_start_burst;
                            r_first          <= 1'b1;
                        end else begin
                            r_start_dropped <= 1'b1;
                        end
                    end
                end
                c_REQ: begin
                    if (data_saved) begin
                        r_start_dropped <= 1'b1;
                    end
                    if (w_mm_accept) begin
                        r_amm_read   <= 1'b0;
                        r_amm_addr   <= r_amm_addr + ADDR_W'(r_amm_burstcount);
                        r_words_left <= r_words_left - 8'(r_amm_burstcount);
                        if (r_words_left == 8'(r_amm_burstcount)) begin
                            r_state <= c_DRAIN;
                        end
                    end else if (!r_amm_read && (r_words_left != 8'd0) &&
                                 (w_credit >= 16'(w_next_burst))) begin
                        r_amm_read       <= 1'b1;
                        r_amm_burstcount <= w_next_burst;
                    end
                end
                c_DRAIN: begin
                    if (data_saved) begin
                        r_start_dropped <= 1'b1;
                    end
                    if (w_frame_end) begin
                        r_state   <= c_IDLE;
                        r_tx_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Serializer: the final word of a frame may carry fewer than 32 bytes.
            if (w_load) begin
                r_word       <= r_mem[r_rd_ptr];
                r_rd_ptr     <= r_rd_ptr + c_AW'(1);
                r_word_valid <= 1'b1;
                r_byte_idx   <= 5'd0;
                if (r_load_left >= 12'd32) begin
                    r_last_idx  <= 5'd31;
                    r_load_left <= r_load_left - 12'd32;
                end else begin
                    r_last_idx  <= 5'(r_load_left - 12'd1);
                    r_load_left <= 12'd0;
                end
            end else if (w_accept) begin
                if (w_word_end) begin
                    r_word_valid <= 1'b0;
                end else begin
                    r_byte_idx <= r_byte_idx + 5'd1;
                end
            end
            if (w_accept) begin
                r_first <= 1'b0;
            end
        end
    end

    assign amm_addr       = r_amm_addr;
    assign amm_read       = r_amm_read;
    assign amm_burstcount = r_amm_burstcount;
    assign amm_byteenable = 32'hFFFF_FFFF;
    assign ff_tx_data     = r_word_valid ? r_word[{r_byte_idx, 3'b000} +: 8] : 8'd0;
    assign ff_tx_sop      = r_word_valid & r_first;
    assign ff_tx_eop      = w_eop;
    assign ff_tx_wren     = r_word_valid;
    assign ff_tx_err      = 1'b0;
    assign ff_tx_crc_fwd  = 1'b0;
    assign tx_busy        = (r_state != c_IDLE);
    assign tx_done        = r_tx_done;
    assign start_dropped  = r_start_dropped;

endmodule
`default_nettype wire
